// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm controller: setting-mode and alarm-sequencer
// state encodings, plus the hour/minute wrap points.
package alarm_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } set_state_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2
  } al_state_t;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/edge_det.sv
// One-bit rising-edge detector: press is high for the single cycle after a 0->1
// transition of level, so a held button yields exactly one press.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: edits the alarm time with mode/inc/dec, compares it against the
// running clock and sequences the buzzer through ringing, snooze and timeout.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       inc,
  input  logic       dec,
  input  logic       snooze,
  input  logic       stop,
  input  logic       alarm_en,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [4:0] al_hrs,
  output logic [5:0] al_min,
  output logic [1:0] set_state,
  output logic       buzz,
  output logic [1:0] snooze_cnt
);

  localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
  localparam logic [1:0] SNOOZE_LIM  = 2'(MAX_SNOOZE);

  logic mode_p, inc_p, dec_p, snooze_p, stop_p;

  edge_det u_mode   (.clk(clk), .rst(rst), .level(mode),   .press(mode_p));
  edge_det u_inc    (.clk(clk), .rst(rst), .level(inc),    .press(inc_p));
  edge_det u_dec    (.clk(clk), .rst(rst), .level(dec),    .press(dec_p));
  edge_det u_snooze (.clk(clk), .rst(rst), .level(snooze), .press(snooze_p));
  edge_det u_stop   (.clk(clk), .rst(rst), .level(stop),   .press(stop_p));

  set_state_t set_q, set_nxt;
  logic [4:0] hrs_nxt;
  logic [5:0] min_nxt;
  logic       step_up, step_dn;

  assign step_up = inc_p & ~dec_p;
  assign step_dn = dec_p & ~inc_p;

  // inc/dec act on the field selected before any simultaneous mode press takes effect
  always_comb begin
    set_nxt = set_q;
    hrs_nxt = al_hrs;
    min_nxt = al_min;
    case (set_q)
      SET_HR: begin
        if (step_up)      hrs_nxt = (al_hrs == HR_MAX) ? 5'd0 : al_hrs + 5'd1;
        else if (step_dn) hrs_nxt = (al_hrs == 5'd0) ? HR_MAX : al_hrs - 5'd1;
      end
      SET_MIN: begin
        if (step_up)      min_nxt = (al_min == MIN_MAX) ? 6'd0 : al_min + 6'd1;
        else if (step_dn) min_nxt = (al_min == 6'd0) ? MIN_MAX : al_min - 6'd1;
      end
      default: ;
    endcase
    if (mode_p) begin
      case (set_q)
        NORMAL:  set_nxt = SET_HR;
        SET_HR:  set_nxt = SET_MIN;
        default: set_nxt = NORMAL;
      endcase
    end
  end

  al_state_t  al_q, al_nxt;
  logic [8:0] scnt, scnt_nxt;
  logic [1:0] cnt_nxt;
  logic [5:0] sec_q;
  logic       sec_tick, match;

  assign sec_tick = (sec != sec_q);
  assign match    = sec_tick && (sec == 6'd0) && (hrs == al_hrs) && (min == al_min)
                    && (set_q == NORMAL);

  // Priority: alarm_en low, then stop, then snooze, then the seconds timeout
  always_comb begin
    al_nxt   = al_q;
    scnt_nxt = scnt;
    cnt_nxt  = snooze_cnt;
    if (!alarm_en) begin
      al_nxt = IDLE;
    end else begin
      case (al_q)
        IDLE: begin
          if (match) begin
            al_nxt   = RINGING;
            scnt_nxt = 9'd0;
            cnt_nxt  = 2'd0;
          end
        end
        RINGING: begin
          if (stop_p) begin
            al_nxt = IDLE;
          end else if (snooze_p && (snooze_cnt < SNOOZE_LIM)) begin
            al_nxt   = SNOOZING;
            scnt_nxt = 9'd0;
            cnt_nxt  = snooze_cnt + 2'd1;
          end else if (sec_tick) begin
            if (scnt == RING_LAST) al_nxt = IDLE;
            else                   scnt_nxt = scnt + 9'd1;
          end
        end
        SNOOZING: begin
          if (stop_p) begin
            al_nxt = IDLE;
          end else if (sec_tick) begin
            if (scnt == SNOOZE_LAST) begin
              al_nxt   = RINGING;
              scnt_nxt = 9'd0;
            end else begin
              scnt_nxt = scnt + 9'd1;
            end
          end
        end
        default: al_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q      <= NORMAL;
      al_hrs     <= 5'd0;
      al_min     <= 6'd0;
      al_q       <= IDLE;
      scnt       <= 9'd0;
      snooze_cnt <= 2'd0;
      sec_q      <= 6'd0;
      buzz       <= 1'b0;
    end else begin
      set_q      <= set_nxt;
      al_hrs     <= hrs_nxt;
      al_min     <= min_nxt;
      al_q       <= al_nxt;
      scnt       <= scnt_nxt;
      snooze_cnt <= cnt_nxt;
      sec_q      <= sec;
      buzz       <= (al_nxt == RINGING);
    end
  end

  assign set_state = set_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random button/time traffic, with a
// seconds-remaining reference model compared against the outputs every cycle.
module tb_alarm_ctrl;

  localparam int RING = 60;
  localparam int SNZ  = 5;
  localparam int MAXS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0, inc = 1'b0, dec = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic       alarm_en = 1'b0;
  logic [4:0] hrs = 5'd0;
  logic [5:0] min = 6'd0;
  logic [5:0] sec = 6'd0;
  logic [4:0] al_hrs;
  logic [5:0] al_min;
  logic [1:0] set_state;
  logic       buzz;
  logic [1:0] snooze_cnt;

  alarm_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk(clk), .rst(rst), .mode(mode), .inc(inc), .dec(dec), .snooze(snooze),
    .stop(stop), .alarm_en(alarm_en), .hrs(hrs), .min(min), .sec(sec),
    .al_hrs(al_hrs), .al_min(al_min), .set_state(set_state), .buzz(buzz),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  // Model: alarm time as integers, alarm phase 0 idle / 1 ringing / 2 snoozing,
  // and the number of seconds left in the current ring or snooze
  int m_hr, m_min, m_set, m_st, m_left, m_sn;
  bit pm, pi, pd, ps, pt;
  int psec;
  int nchecks = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hr = 0; m_min = 0; m_set = 0; m_st = 0; m_left = 0; m_sn = 0;
    pm = 0; pi = 0; pd = 0; ps = 0; pt = 0; psec = 0;
  endtask

  task automatic model_step();
    bit p_mode, p_inc, p_dec, p_snz, p_stop, tick_now;
    int d;
    p_mode = mode && !pm;
    p_inc  = inc && !pi;
    p_dec  = dec && !pd;
    p_snz  = snooze && !ps;
    p_stop = stop && !pt;
    tick_now = (int'(sec) != psec);
    if (!alarm_en) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (tick_now && sec == 0 && int'(hrs) == m_hr && int'(min) == m_min && m_set == 0) begin
        m_st = 1; m_left = RING; m_sn = 0;
      end
    end else if (p_stop) begin
      m_st = 0;
    end else if (m_st == 1) begin
      if (p_snz && m_sn < MAXS) begin
        m_st = 2; m_left = SNZ; m_sn++;
      end else if (tick_now) begin
        m_left--;
        if (m_left == 0) m_st = 0;
      end
    end else if (tick_now) begin
      m_left--;
      if (m_left == 0) begin m_st = 1; m_left = RING; end
    end
    if (p_inc != p_dec) begin
      d = p_inc ? 1 : -1;
      if (m_set == 1)      m_hr  = (m_hr + d + 24) % 24;
      else if (m_set == 2) m_min = (m_min + d + 60) % 60;
    end
    if (p_mode) m_set = (m_set + 1) % 3;
    pm = mode; pi = inc; pd = dec; ps = snooze; pt = stop;
    psec = int'(sec);
  endtask

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("al_hrs", int'(al_hrs), m_hr);
      check("al_min", int'(al_min), m_min);
      check("set_state", int'(set_state), m_set);
      check("buzz", int'(buzz), (m_st == 1) ? 1 : 0);
      check("snooze_cnt", int'(snooze_cnt), m_sn);
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    #2;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: mode = v;
      1: inc = v;
      2: dec = v;
      3: snooze = v;
      default: stop = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1); cyc();
    set_btn(b, 1'b0); cyc();
  endtask

  task automatic press2(input int a, input int b);
    set_btn(a, 1'b1); set_btn(b, 1'b1); cyc();
    set_btn(a, 1'b0); set_btn(b, 1'b0); cyc();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hrs = 5'(h); min = 6'(m); sec = 6'(s);
  endtask

  task automatic advance_time();
    int h, m, s;
    h = int'(hrs); m = int'(min); s = int'(sec) + 1;
    if (s == 60) begin s = 0; m++; end
    if (m == 60) begin m = 0; h++; end
    if (h == 24) h = 0;
    set_time(h, m, s);
  endtask

  task automatic tick();
    advance_time(); cyc();
  endtask

  task automatic trigger();
    set_time(7, 29, 59); cyc();
    set_time(7, 30, 0);  cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;
    chk_on = 1'b1;
    check("reset_buzz", int'(buzz), 0);
    check("reset_al_hrs", int'(al_hrs), 0);
    check("reset_set_state", int'(set_state), 0);
    check("reset_snooze_cnt", int'(snooze_cnt), 0);

    // mode, inc x7, mode, dec, mode
    press(0);
    repeat (7) press(1);
    press(0); press(2); press(0);
    check("seq_al_hrs", int'(al_hrs), 7);
    check("seq_al_min", int'(al_min), 59);
    check("seq_set_state", int'(set_state), 0);
    check("model_pin_hr", m_hr, 7);

    // wrap-around in both fields
    press(0);
    repeat (16) press(1);
    check("hr_23", int'(al_hrs), 23);
    press(1);
    check("hr_wrap_up", int'(al_hrs), 0);
    press(0);
    press(1);
    check("min_wrap_up", int'(al_min), 0);
    press(2);
    check("min_wrap_dn", int'(al_min), 59);
    press(0);

    // simultaneous mode+inc and inc+dec
    press(0);
    repeat (5) press(1);
    press2(0, 1);
    check("mode_inc_hrs", int'(al_hrs), 6);
    check("mode_inc_state", int'(set_state), 2);
    press2(1, 2);
    check("inc_dec_min", int'(al_min), 59);
    press(0);

    // program 07:30
    press(0); press(1); press(0);
    repeat (29) press(2);
    press(0);
    check("prog_hrs", int'(al_hrs), 7);
    check("prog_min", int'(al_min), 30);

    // ring and auto-stop after exactly RING ticks
    alarm_en = 1'b1;
    set_time(7, 29, 55); cyc();
    check("pre_ring_buzz", int'(buzz), 0);
    trigger();
    check("ring_start", int'(buzz), 1);
    for (int k = 1; k <= RING; k++) begin
      tick();
      if (k == RING - 1) check("ring_last_tick", int'(buzz), 1);
      if (k == RING)     check("ring_timeout", int'(buzz), 0);
    end

    // snooze limit
    trigger();
    for (int i = 0; i < 4; i++) begin
      press(3);
      if (i < 3) begin
        check("snoozing_buzz", int'(buzz), 0);
        check("snoozing_cnt", int'(snooze_cnt), i + 1);
        repeat (SNZ) tick();
        check("rering_buzz", int'(buzz), 1);
      end else begin
        check("snooze_ignored_buzz", int'(buzz), 1);
        check("snooze_ignored_cnt", int'(snooze_cnt), 3);
      end
    end
    press(4);
    check("stop_buzz", int'(buzz), 0);

    // alarm_en drop while snoozing
    trigger();
    press(3);
    alarm_en = 1'b0; cyc();
    alarm_en = 1'b1;
    repeat (10) tick();
    check("en_drop_no_rering", int'(buzz), 0);

    // no trigger while editing minutes
    press(0); press(0);
    trigger();
    tick();
    check("set_min_no_ring", int'(buzz), 0);
    press(0);

    // asynchronous reset mid-ring
    trigger();
    repeat (3) tick();
    check("pre_reset_buzz", int'(buzz), 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_buzz", int'(buzz), 0);
    check("async_rst_al_hrs", int'(al_hrs), 0);
    check("async_rst_al_min", int'(al_min), 0);
    #1;
    cyc(); cyc();
    rst = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      mode     = ($urandom_range(0, 31) == 0);
      inc      = ($urandom_range(0, 7) == 0);
      dec      = ($urandom_range(0, 7) == 0);
      snooze   = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 31) == 0);
      alarm_en = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) begin
        int h, m;
        h = m_hr; m = m_min - 1;
        if (m < 0) begin m = 59; h = (h + 23) % 24; end
        set_time(h, m, 59);
      end else if ($urandom_range(0, 1) == 0) begin
        advance_time();
      end
      cyc();
    end
    mode = 0; inc = 0; dec = 0; snooze = 0; stop = 0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
